// File: rtl/main_controller.sv
// Multi-cycle MIPS main control FSM: sequences fetch/decode/execute/memory/writeback
// and drives the datapath enables, mux selects and the ALUOp code for ALUDecoder.
module main_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic       Zero,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSrc,
  output logic       PCEn,
  output logic       Illegal,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t state_q;
  state_t state_d;
  logic   pc_write;
  logic   branch;
  logic   op_supported;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; combinational blocks below use blocking assignments.
  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  assign op_supported = Op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};

  // NOTE: state_d gets a default before the case so no path can infer a latch;
  // the unreachable encodings 12-15 fall through to FETCH here.
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:   state_d = DECODE;
      DECODE: begin
        case (Op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXECUTE;
          OP_BEQ:       state_d = BRANCH;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JUMP;
          default:      state_d = FETCH;
        endcase
      end
      MEMADR:  state_d = (Op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:   state_d = MEMWB;
      EXECUTE: state_d = ALUWB;
      ADDIEX:  state_d = ADDIWB;
      default: state_d = FETCH;
    endcase
  end

  // Moore outputs: everything not set in a state stays at its default of 0.
  always_comb begin
    IorD     = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    ALUOp    = 2'b00;
    PCSrc    = 2'b00;
    pc_write = 1'b0;
    branch   = 1'b0;
    case (state_q)
      FETCH: begin
        IRWrite  = 1'b1;
        pc_write = 1'b1;
        ALUSrcB  = 2'b01;
      end
      DECODE:  ALUSrcB = 2'b11;
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      MEMRD:   IorD = 1'b1;
      MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      EXECUTE: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      BRANCH: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b01;
        PCSrc   = 2'b01;
        branch  = 1'b1;
      end
      ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      ADDIWB:  RegWrite = 1'b1;
      JUMP: begin
        PCSrc    = 2'b10;
        pc_write = 1'b1;
      end
      default: ;
    endcase
  end

  assign PCEn    = pc_write | (branch & Zero);
  assign Illegal = (state_q == DECODE) && !op_supported;
  assign State   = state_q;

endmodule

// File: tb/tb_main_controller.sv
// Self-checking bench for main_controller: directed per-instruction scenarios plus a
// randomized instruction stream checked against an opcode-path / state-table model.
module tb_main_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] Op;
  logic       Zero;
  logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSrc;
  logic       PCEn, Illegal;
  logic [3:0] State;

  int checks   = 0;
  int failures = 0;

  main_controller dut (
    .clk(clk), .reset(reset), .Op(Op), .Zero(Zero),
    .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc), .PCEn(PCEn),
    .Illegal(Illegal), .State(State)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;

  // Per-state expected control word, in port order:
  // {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSrc}
  typedef struct packed {
    logic iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, aluop, pcsrc;
  } ctrl_t;

  ctrl_t spec_ctrl [12];
  bit    writes_pc [12];
  bit    is_branch [12];

  task automatic build_table();
    for (int s = 0; s < 12; s++) begin
      spec_ctrl[s] = '0;
      writes_pc[s] = 1'b0;
      is_branch[s] = 1'b0;
    end
    spec_ctrl[0].irwrite = 1; spec_ctrl[0].alusrcb = 2'b01; writes_pc[0] = 1;
    spec_ctrl[1].alusrcb = 2'b11;
    spec_ctrl[2].alusrca = 1; spec_ctrl[2].alusrcb = 2'b10;
    spec_ctrl[3].iord = 1;
    spec_ctrl[4].memtoreg = 1; spec_ctrl[4].regwrite = 1;
    spec_ctrl[5].iord = 1; spec_ctrl[5].memwrite = 1;
    spec_ctrl[6].alusrca = 1; spec_ctrl[6].aluop = 2'b10;
    spec_ctrl[7].regdst = 1; spec_ctrl[7].regwrite = 1;
    spec_ctrl[8].alusrca = 1; spec_ctrl[8].aluop = 2'b01; spec_ctrl[8].pcsrc = 2'b01;
    is_branch[8] = 1;
    spec_ctrl[9].alusrca = 1; spec_ctrl[9].alusrcb = 2'b10;
    spec_ctrl[10].regwrite = 1;
    spec_ctrl[11].pcsrc = 2'b10; writes_pc[11] = 1;
  endtask

  function automatic bit legal(input logic [5:0] op);
    return op inside {LW, SW, RT, BEQ, ADDI, JMP};
  endfunction

  // States an instruction visits, FETCH through its last state.
  function automatic void instr_path(input logic [5:0] op, output int p[$]);
    p = {0, 1};
    case (op)
      LW:      p = {p, 2, 3, 4};
      SW:      p = {p, 2, 5};
      RT:      p = {p, 6, 7};
      BEQ:     p = {p, 8};
      ADDI:    p = {p, 9, 10};
      JMP:     p = {p, 11};
      default: ;
    endcase
  endfunction

  // Runs one instruction from FETCH, checking every cycle, then its return to FETCH.
  task automatic run_instr(input string name, input logic [5:0] op,
                           input bit force_zero, input logic zero_val);
    int    p[$];
    ctrl_t obs, exp;
    logic  exp_pcen, exp_ill;
    instr_path(op, p);
    Op = op;
    foreach (p[i]) begin
      Zero = force_zero ? zero_val : 1'($urandom_range(0, 1));
      #1;
      obs = {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSrc};
      exp = spec_ctrl[p[i]];
      exp_pcen = writes_pc[p[i]] | (is_branch[p[i]] & Zero);
      exp_ill  = (p[i] == 1) && !legal(op);
      checks++;
      if (State !== 4'(p[i])) begin
        failures++;
        $display("FAIL %s state step %0d: got %0d want %0d", name, i, State, p[i]);
      end
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL %s ctrl in state %0d: got %b want %b", name, p[i], obs, exp);
      end
      checks++;
      if (PCEn !== exp_pcen) begin
        failures++;
        $display("FAIL %s PCEn in state %0d: got %b want %b", name, p[i], PCEn, exp_pcen);
      end
      checks++;
      if (Illegal !== exp_ill) begin
        failures++;
        $display("FAIL %s Illegal in state %0d: got %b want %b", name, p[i], Illegal, exp_ill);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (State !== 4'd0) begin
      failures++;
      $display("FAIL %s return after %0d cycles: got state %0d want 0", name, p.size(), State);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; Op = LW; Zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (State !== 4'd0 || IRWrite !== 1'b1 || PCEn !== 1'b1 || ALUSrcB !== 2'b01 ||
        Illegal !== 1'b0 || RegWrite !== 1'b0 || MemWrite !== 1'b0 || PCSrc !== 2'b00) begin
      failures++;
      $display("FAIL reset_state: got st=%0d ir=%b pcen=%b srcb=%b ill=%b rw=%b mw=%b want 0 1 1 01 0 0 0",
               State, IRWrite, PCEn, ALUSrcB, Illegal, RegWrite, MemWrite);
    end
    reset = 1'b0;
  endtask

  // Reset asserted while the instruction sits in path position 'at'.
  task automatic test_mid_reset(input string name, input logic [5:0] op, input int at);
    int p[$];
    instr_path(op, p);
    Op = op;
    for (int i = 0; i < at; i++) begin
      Zero = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    checks++;
    if (State !== 4'(p[at]) || RegWrite !== spec_ctrl[p[at]].regwrite) begin
      failures++;
      $display("FAIL %s pre-reset: got st=%0d rw=%b want st=%0d", name, State, RegWrite, p[at]);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (State !== 4'd0 || RegWrite !== 1'b0 || MemWrite !== 1'b0 || IRWrite !== 1'b1) begin
      failures++;
      $display("FAIL %s post-reset: got st=%0d rw=%b mw=%b ir=%b want 0 0 0 1",
               name, State, RegWrite, MemWrite, IRWrite);
    end
    reset = 1'b0;
  endtask

  task automatic test_back_to_back_random();
    logic [5:0] ops [6] = '{LW, SW, RT, BEQ, ADDI, JMP};
    logic [5:0] op;
    for (int n = 0; n < 40; n++) begin
      op = ($urandom_range(0, 4) == 0) ? 6'($urandom) : ops[$urandom_range(0, 5)];
      run_instr($sformatf("rand%0d_op%b", n, op), op, 1'b0, 1'b0);
    end
  endtask

  initial begin
    build_table();
    test_reset();
    run_instr("lw", LW, 1'b0, 1'b0);
    run_instr("sw", SW, 1'b0, 1'b0);
    run_instr("rtype", RT, 1'b0, 1'b0);
    run_instr("beq_taken", BEQ, 1'b1, 1'b1);
    run_instr("beq_not_taken", BEQ, 1'b1, 1'b0);
    run_instr("addi", ADDI, 1'b0, 1'b0);
    run_instr("j", JMP, 1'b0, 1'b0);
    run_instr("illegal_3f", 6'b111111, 1'b0, 1'b0);
    test_mid_reset("lw_reset_memrd", LW, 3);
    test_mid_reset("sw_reset_memwr", SW, 3);
    test_mid_reset("rt_reset_aluwb", RT, 3);
    test_mid_reset("lw_reset_memwb", LW, 4);
    test_back_to_back_random();
    for (int k = 0; k < 6; k++) begin
      logic [5:0] op;
      int         p[$];
      op = (k % 2 == 0) ? LW : ADDI;
      instr_path(op, p);
      test_mid_reset($sformatf("rand_reset%0d", k), op, $urandom_range(0, p.size() - 1));
    end
    run_instr("lw_after_resets", LW, 1'b0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/main_controller.md
# main_controller

Multi-cycle main control FSM for the MIPS datapath. It sequences each instruction through fetch, decode, execute, memory and writeback states, driving the datapath enables and muxes. It produces the 2-bit `ALUOp` consumed directly by `ALUDecoder`, which combines `ALUOp` with `Funct` to form `ALUSel`.

## Interface

Parameters:
- none. State encoding is fixed, as listed under Operation.

Ports:
- `clk`  in  1  system clock; all state updates occur on the rising edge.
- `reset`  in  1  synchronous, active-high. One clock; reset is synchronous and active-high.
- `Op`  in  6  opcode field `Instr[31:26]` from the instruction register.
- `Zero`  in  1  ALU zero flag.
- `IorD`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `MemWrite`  out  1  memory write enable.
- `IRWrite`  out  1  instruction register load.
- `RegDst`  out  1  destination register select: 0 = rt, 1 = rd.
- `MemtoReg`  out  1  writeback source select: 0 = ALUOut, 1 = Data.
- `RegWrite`  out  1  register file write enable.
- `ALUSrcA`  out  1  ALU A input select: 0 = PC, 1 = A.
- `ALUSrcB`  out  2  ALU B input select: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2.
- `ALUOp`  out  2  to `ALUDecoder`: 00 = add, 01 = sub, 10 = decode `Funct`.
- `PCSrc`  out  2  next-PC select: 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- `PCEn`  out  1  PC load enable, `PCWrite | (Branch & Zero)`.
- `Illegal`  out  1  one-cycle pulse when an unsupported opcode is decoded.
- `State`  out  4  current state, for debug and verification.

## Operation

Supported opcodes:
- R-type: 000000
- lw: 100011
- sw: 101011
- beq: 000100
- addi: 001000
- j: 000010

States, their encoding, and the outputs asserted in each. Every output not listed is 0 in that state.
- FETCH (0): IRWrite=1, PCWrite=1, ALUSrcB=01, ALUOp=00. Next state is DECODE.
- DECODE (1): ALUSrcB=11, ALUOp=00. Next state depends on `Op`:
  - lw or sw → MEMADR
  - R-type → EXECUTE
  - beq → BRANCH
  - addi → ADDIEX
  - j → JUMP
  - any other opcode → FETCH, with `Illegal`=1 during this DECODE cycle.
- MEMADR (2): ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next state is MEMRD for lw, MEMWR for sw (`Op` is held stable by the IR).
- MEMRD (3): IorD=1. Next state is MEMWB.
- MEMWB (4): MemtoReg=1, RegWrite=1. Next state is FETCH.
- MEMWR (5): IorD=1, MemWrite=1. Next state is FETCH.
- EXECUTE (6): ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next state is ALUWB.
- ALUWB (7): RegDst=1, RegWrite=1. Next state is FETCH.
- BRANCH (8): ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch=1 (internal). Next state is FETCH.
- ADDIEX (9): ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next state is ADDIWB.
- ADDIWB (10): RegWrite=1. Next state is FETCH.
- JUMP (11): PCSrc=10, PCWrite=1. Next state is FETCH.
- Encodings 12–15 are unreachable. If entered, they drive all outputs to 0 and return to FETCH on the next edge.

Output and reset rules:
- All outputs except `Illegal` and `PCEn` are pure Moore functions of the state register.
- `Illegal` is a function of state and `Op`.
- `PCEn` is a function of state and `Zero`.
- Reset has priority over every transition. `reset` high at a rising edge forces `State` to FETCH (0), including mid-instruction.
- After the reset edge, outputs equal the FETCH values: IRWrite=1, PCWrite=1, `PCEn`=1, ALUSrcB=01, all others 0, `Illegal`=0.
- `MemWrite` and `RegWrite` are never asserted in FETCH or DECODE. A reset during MEMWR or any writeback state suppresses that write from the next cycle onward.

## Timing

- One state per clock; the state register updates on the rising edge of `clk`.
- Instruction latency in cycles, counted from FETCH to the return to FETCH:
  - lw 5
  - sw 4
  - R-type 4
  - addi 4
  - beq 3
  - j 3
  - illegal opcode 2
- `Op` is sampled in DECODE and MEMADR only. `Zero` is used only in BRANCH.
- `PCEn` in BRANCH follows `Zero` combinationally within the same cycle. No registered outputs are added.
- The `ALUOp`→`ALUSel` path through `ALUDecoder` must complete within a single cycle. `ALUOp` is stable for the whole state.

## Test plan

- Reset and lw:
  - Hold `reset`=1 for 2 cycles, release, `Op`=100011.
  - Required: `State` sequence 0,1,2,3,4,0.
  - Required: `RegWrite`=1 and `MemtoReg`=1 only in state 4; `IorD`=1 only in state 3.
- sw then R-type:
  - `Op`=101011, then 000000.
  - Required: sw visits 0,1,2,5 with `MemWrite`=1 only in state 5.
  - Required: R-type visits 0,1,6,7 with `ALUOp`=10 in state 6, and `RegDst`=1, `RegWrite`=1 in state 7.
- beq with `Zero`=1, then beq with `Zero`=0:
  - Required: in state 8, `ALUOp`=01, `PCSrc`=01, and `PCEn`=1 for `Zero`=1 and `PCEn`=0 for `Zero`=0.
  - Required: return to FETCH after 3 cycles in both cases.
- addi and j:
  - `Op`=001000 → states 0,1,9,10 with `ALUSrcB`=10 in state 9.
  - `Op`=000010 → states 0,1,11 with `PCSrc`=10 and `PCEn`=1 in state 11.
- Illegal opcode and mid-instruction reset:
  - `Op`=111111 → `Illegal`=1 for exactly the one DECODE cycle, then `State`=0.
  - Assert `reset` during state 3 of a lw → `State`=0 next cycle, and `RegWrite` is never asserted.
